// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared FSM state type and parameter defaults for the multiplier-sharing arbiter
package mul_arb_pkg;
    localparam int N_REQ_DEF   = 4;
    localparam int W_DEF       = 8;
    localparam int TIMEOUT_DEF = 64;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin search for the first asserted request after the last grant
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_gnt,
    output logic [N_REQ-1:0] onehot,
    output logic [IW-1:0]    idx,
    output logic             any
);
    // Scanning from the farthest offset down lets the nearest requester overwrite earlier hits.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req[(int'(last_gnt) + k) % N_REQ]) begin
                idx = IW'((int'(last_gnt) + k) % N_REQ);
                any = 1'b1;
            end
        end
    end
    assign onehot = any ? {{(N_REQ-1){1'b0}}, 1'b1} << idx : '0;
endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one multiplier among N_REQ requesters, with timeout
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int W       = W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*W-1:0]         op_x,
    input  logic [N_REQ*W-1:0]         op_y,
    output logic [N_REQ-1:0]           gnt,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [2*W-1:0]             rsp_prod,
    output logic                       rsp_err,
    output logic                       mul_start,
    output logic [W-1:0]               mul_x,
    output logic [W-1:0]               mul_y,
    input  logic                       mul_done,
    input  logic [2*W-1:0]             mul_prod
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t state, state_nxt;
    logic [N_REQ-1:0] win_oh;
    logic [IW-1:0]    win_idx, last_gnt;
    logic             win_any, timeout, done_ok, resp_go;
    logic [CW-1:0]    cnt;
    rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req      (req),
        .last_gnt (last_gnt),
        .onehot   (win_oh),
        .idx      (win_idx),
        .any      (win_any)
    );
    assign timeout   = cnt == CW'(TIMEOUT - 1);
    assign done_ok   = state == WAIT_DONE && mul_done;
    assign resp_go   = state_nxt == RESP && state != RESP;
    assign mul_start = state == ISSUE;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = win_any ? ISSUE : IDLE;
            ISSUE:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: state_nxt = !mul_done ? WAIT_DONE : timeout ? RESP : WAIT_BUSY;
            WAIT_DONE: state_nxt = (mul_done || timeout) ? RESP : WAIT_DONE;
            RESP:      state_nxt = rsp_ready ? IDLE : RESP;
            default:   state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt       <= '0;
            last_gnt  <= IW'(N_REQ - 1);
            mul_x     <= '0;
            mul_y     <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_prod  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            cnt <= (state == WAIT_BUSY || state == WAIT_DONE) ? cnt + 1'b1 : '0;
            if (state == IDLE && win_any) begin
                gnt      <= win_oh;
                last_gnt <= win_idx;
                mul_x    <= op_x[win_idx*W +: W];
                mul_y    <= op_y[win_idx*W +: W];
            end
            // A completed multiply wins over a timeout expiring on the same cycle.
            if (resp_go) begin
                rsp_valid <= 1'b1;
                rsp_id    <= last_gnt;
                rsp_err   <= !done_ok;
                rsp_prod  <= done_ok ? mul_prod : '0;
            end
            if (state == RESP && rsp_ready) begin
                gnt       <= '0;
                rsp_valid <= 1'b0;
                rsp_err   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: scoreboard bench with a Booth-multiplier stub for mul_share_arbiter
module tb_mul_share_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 64;
    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] prod;
        logic        err;
    } rsp_t;
    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] op_x = '0;
    logic [N*W-1:0] op_y = '0;
    logic [N-1:0]   gnt;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [1:0]     rsp_id;
    logic [2*W-1:0] rsp_prod;
    logic           rsp_err;
    logic           mul_start;
    logic [W-1:0]   mul_x, mul_y;
    logic           mul_done;
    logic [2*W-1:0] mul_prod;
    int   n_tests = 0;
    int   n_fail = 0;
    int   start_cnt = 0;
    int   s0, lat;
    int   stub_lat = 3;
    bit   stub_hang = 1'b0;
    int   busy = 0;
    logic [W-1:0] px = '0, py = '0;
    rsp_t exp_q[$];
    rsp_t mon_e;
    mul_share_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op_x      (op_x),
        .op_y      (op_y),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod),
        .rsp_err   (rsp_err),
        .mul_start (mul_start),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_done  (mul_done),
        .mul_prod  (mul_prod)
    );
    always #5 clk = ~clk;
    // Multiplier stub: idle reports done; a start makes it busy for stub_lat cycles.
    always @(posedge clk) begin
        if (rst) busy <= 0;
        else if (mul_start && !stub_hang) begin
            busy <= stub_lat;
            px   <= mul_x;
            py   <= mul_y;
        end else if (busy > 0) busy <= busy - 1;
    end
    assign mul_done = busy == 0;
    assign mul_prod = {{W{px[W-1]}}, px} * {{W{py[W-1]}}, py};
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic set_op(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
        op_x[i*W +: W] = x;
        op_y[i*W +: W] = y;
    endtask
    task automatic push(input logic [1:0] id, input logic [15:0] prod, input logic err);
        exp_q.push_back('{id: id, prod: prod, err: err});
    endtask
    task automatic wait_drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 500) begin
            tick();
            k++;
        end
        chk(name, 64'(exp_q.size()), 0);
        tick(2);
    endtask
    task automatic wait_sig(input string name, input int which, input int bound);
        int k = 0;
        while (!(which == 0 ? mul_start : rsp_valid) && k < bound) begin
            tick();
            k++;
        end
        chk(name, which == 0 ? mul_start : rsp_valid, 1);
    endtask
    // Monitor: pop and compare on each handshake, then drop the served request.
    initial forever begin
        @(negedge clk);
        if (mul_start) start_cnt++;
        if (rsp_valid && rsp_ready && !rst) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp: got id %0d prod %0h err %0b, none expected", rsp_id, rsp_prod, rsp_err);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_id", 64'(rsp_id), 64'(mon_e.id));
                chk("rsp_prod", 64'(rsp_prod), 64'(mon_e.prod));
                chk("rsp_err", 64'(rsp_err), 64'(mon_e.err));
            end
            req[rsp_id] = 1'b0;
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
    initial begin
        tick(2);
        chk("reset_outs", {gnt, mul_start, mul_x, mul_y, rsp_valid, rsp_id, rsp_prod, rsp_err}, 0);
        rst = 1'b0;
        set_op(2, 8'd5, 8'hFD);
        push(2'd2, 16'hFFF1, 1'b0);
        s0 = start_cnt;
        req[2] = 1'b1;
        tick();
        chk("A_start_hi", 64'(mul_start), 1);
        chk("A_gnt", 64'(gnt), 4'b0100);
        chk("A_mul_x", 64'(mul_x), 5);
        tick();
        chk("A_start_lo", 64'(mul_start), 0);
        wait_drain("A_drain");
        chk("A_start_cnt", 64'(start_cnt - s0), 1);
        chk("A_gnt_clr", 64'(gnt), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_op(0, 8'd1, 8'd2);
        set_op(1, 8'd2, 8'd3);
        set_op(2, 8'd3, 8'd4);
        set_op(3, 8'hFC, 8'd5);
        push(2'd0, 16'd2, 1'b0);
        push(2'd1, 16'd6, 1'b0);
        push(2'd2, 16'd12, 1'b0);
        push(2'd3, 16'hFFEC, 1'b0);
        req = 4'b1111;
        wait_drain("B_all_drain");
        push(2'd1, 16'd6, 1'b0);
        push(2'd3, 16'hFFEC, 1'b0);
        req = 4'b1010;
        wait_drain("B_13_drain");
        rsp_ready = 1'b0;
        set_op(0, 8'hF9, 8'hF7);
        req = 4'b0011;
        wait_sig("C_valid", 1, 100);
        s0 = start_cnt;
        repeat (10) begin
            tick();
            chk("C_hold_valid", 64'(rsp_valid), 1);
            chk("C_hold_prod", 64'(rsp_prod), 16'h003F);
            chk("C_hold_gnt", 64'(gnt), 4'b0001);
        end
        chk("C_no_start", 64'(start_cnt - s0), 0);
        push(2'd0, 16'h003F, 1'b0);
        push(2'd1, 16'd6, 1'b0);
        rsp_ready = 1'b1;
        tick();
        chk("C_done_1cyc", 64'(rsp_valid), 0);
        wait_drain("C_drain");
        stub_hang = 1'b1;
        set_op(3, 8'd7, 8'd7);
        push(2'd3, 16'd0, 1'b1);
        rsp_ready = 1'b0;
        req[3] = 1'b1;
        wait_sig("D_start", 0, 20);
        lat = 0;
        while (!rsp_valid && lat < 3 * TO) begin
            tick();
            lat++;
        end
        chk("D_latency_ok", 64'(lat >= TO && lat <= TO + 1), 1);
        chk("D_err", 64'(rsp_err), 1);
        chk("D_prod", 64'(rsp_prod), 0);
        rsp_ready = 1'b1;
        wait_drain("D_drain");
        chk("D_gnt_clr", 64'(gnt), 0);
        stub_hang = 1'b0;
        push(2'd1, 16'd6, 1'b0);
        req[1] = 1'b1;
        wait_drain("D_idle_again");
        stub_lat = 20;
        set_op(0, 8'd3, 8'd3);
        req[0] = 1'b1;
        wait_sig("E_start", 0, 20);
        tick(4);
        chk("E_mul_busy", 64'(mul_done), 0);
        rst = 1'b1;
        tick();
        chk("E_rst_outs", {gnt, mul_start, mul_x, mul_y, rsp_valid, rsp_id, rsp_prod, rsp_err}, 0);
        rst = 1'b0;
        stub_lat = 3;
        push(2'd0, 16'd9, 1'b0);
        push(2'd1, 16'd6, 1'b0);
        req = 4'b0011;
        wait_drain("E_drain");
        chk("queue_empty", 64'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mul_share_arbiter.md
MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters (2..8).
REQ-002 Parameter W, default 8: operand width in bits; products are 2W bits.
REQ-003 Parameter TIMEOUT, default 64: maximum cycles allowed for the multiplier to finish.
REQ-004 clk  input  1  clock; all state changes on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  N_REQ  per-requester request level.
REQ-007 op_x  input  N_REQ*W  multiplicand bus; slice i belongs to requester i.
REQ-008 op_y  input  N_REQ*W  multiplier bus; slice i belongs to requester i.
REQ-009 gnt  output  N_REQ  one-hot grant, registered.
REQ-010 rsp_valid, rsp_ready  output/input  1 each  response handshake.
REQ-011 rsp_id  output  clog2(N_REQ)  index of the served requester.
REQ-012 rsp_prod  output  2W  signed product.
REQ-013 rsp_err  output  1  response was produced by a timeout.
REQ-014 mul_start, mul_x, mul_y  output  1/W/W  drive the shared Booth multiplier.
REQ-015 mul_done, mul_prod  input  1/2W  multiplier status and result; mul_done is high while the multiplier is idle.

Function
REQ-016 The FSM SHALL have five states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
REQ-017 req SHALL be sampled in IDLE only.
- Winner is the first asserted req at or after index last_gnt+1, modulo N_REQ.
REQ-018 On a win in IDLE:
- op_x/op_y slices are latched into mul_x/mul_y.
- gnt is set one-hot, last_gnt is updated.
- Next state is ISSUE; with no req, stay in IDLE.
REQ-019 ISSUE SHALL assert mul_start for exactly one cycle, then go to WAIT_BUSY.
- mul_start rises the cycle after req is sampled.
REQ-020 WAIT_BUSY SHALL advance to WAIT_DONE on the first cycle mul_done==0.
REQ-021 WAIT_DONE SHALL, on mul_done==1:
- Capture mul_prod into rsp_prod.
- Set rsp_valid=1, rsp_id=granted index, rsp_err=0.
- Go to RESP.
REQ-022 A cycle counter SHALL run during WAIT_BUSY and WAIT_DONE.
- On reaching TIMEOUT-1: rsp_valid=1, rsp_err=1, rsp_prod=0, go to RESP.
REQ-023 RESP SHALL hold rsp_valid, rsp_id, rsp_prod and rsp_err stable until rsp_valid&&rsp_ready.
- On that cycle: clear gnt, rsp_valid and rsp_err; go to IDLE.
REQ-024 No new grant or mul_start SHALL occur while not in IDLE.
- req changes outside IDLE are ignored.
REQ-025 A requester SHALL deassert req no later than the cycle after its handshake.
- A req still high in IDLE is treated as a new request.
REQ-026 mul_x and mul_y SHALL stay constant from ISSUE until RESP exits.
REQ-027 The multiplier's result timing SHALL have no effect on arbitration order.

Reset
REQ-028 On rst, all outputs SHALL be zero in the following cycle: gnt, mul_start, mul_x, mul_y, rsp_valid, rsp_id, rsp_prod, rsp_err.
REQ-029 On rst, the state SHALL return to IDLE, the timeout counter SHALL clear, and last_gnt SHALL be set to N_REQ-1.
REQ-030 rst SHALL take priority over every transition, including a mid-operation abort; no response is issued for an aborted grant.

Structure
REQ-031 Package mul_arb_pkg SHALL hold the state enum and the default values of N_REQ, W and TIMEOUT.
REQ-032 The round-robin search SHALL be one sub-module, rr_pick: req, last_gnt -> one-hot winner, index, any.

Verification
REQ-033 Single request: requester 2 with op_x=5, op_y=-3 -> rsp_id=2, rsp_prod=16'hFFF1, rsp_err=0; mul_start is high exactly one cycle.
REQ-034 Fairness: all four req high after reset -> served in order 0,1,2,3; then req{1,3} high -> order 1,3.
REQ-035 Backpressure: rsp_ready held low 10 cycles -> rsp_valid and rsp_prod stay stable and no mul_start occurs; when rsp_ready rises the response completes in 1 cycle.
REQ-036 Timeout: multiplier stub keeps mul_done=1 forever -> after TIMEOUT cycles, rsp_valid=1, rsp_err=1, rsp_prod=0, and the arbiter returns to IDLE after the handshake.
REQ-037 Reset mid-operation: rst asserted in WAIT_DONE -> all outputs are 0 next cycle, and the next request from requester 0 wins first.
